register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 27 ++
 rtl/register_file.sv | 44 ++++
 tb/tb_register_file.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bus: two read ports, one debug read port, one write port
// and the committed-write counter. clk and reset stay outside as plain ports.
interface register_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] read_reg1;
   logic [ADDR_WIDTH-1:0] read_reg2;
   logic [ADDR_WIDTH-1:0] write_reg;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  reg_write;
   logic [ADDR_WIDTH-1:0] debug_reg;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;
   logic [DATA_WIDTH-1:0] debug_data;
   logic [15:0]           write_count;

   modport master (
      output read_reg1, read_reg2, write_reg, write_data, reg_write, debug_reg,
      input  read_data1, read_data2, debug_data, write_count
   );

   modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, reg_write, debug_reg,
      output read_data1, read_data2, debug_data, write_count
   );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, register 0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports 1 and 2.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic            clk,
   input logic            reset,
   register_file_if.slave bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [15:0]           write_count;
   logic                  commit;

   assign commit = bus.reg_write && (bus.write_reg != '0) && !reset;

   // NOTE: every entry has an asynchronous clear, so the array becomes flops rather
   // than an inferred RAM; the contents must vanish the instant reset rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         write_count <= '0;
      end else if (commit) begin
         // NOTE: non-blocking, so reads in the write cycle still see the old contents.
         regs[bus.write_reg] <= bus.write_data;
         write_count         <= write_count + 16'd1;
      end
   end

   always_comb begin
      bus.read_data1 = (bus.read_reg1 == '0) ? '0 : regs[bus.read_reg1];
      bus.read_data2 = (bus.read_reg2 == '0) ? '0 : regs[bus.read_reg2];
`ifdef REGFILE_BYPASS_EN
      if (commit && (bus.read_reg1 == bus.write_reg)) bus.read_data1 = bus.write_data;
      if (commit && (bus.read_reg2 == bus.write_reg)) bus.read_data2 = bus.write_data;
`endif
   end

   // The debug port always shows stored contents, even with forwarding enabled.
   assign bus.debug_data  = (bus.debug_reg == '0) ? '0 : regs[bus.debug_reg];
   assign bus.write_count = write_count;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vectors, literal expectations and a per-cycle
// comparison against an array-based model of the register file.
`timescale 1ns/1ps
module tb_register_file;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk;
   logic reset;
   logic check_en;
   int   n_checks;
   int   n_pass;

   register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Model: stored contents plus a plain count of committed writes.
   logic [DW-1:0] model_regs [32];
   int            model_writes;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model_regs[i] <= '0;
         model_writes <= 0;
      end else if (bus.reg_write && bus.write_reg != 0) begin
         model_regs[bus.write_reg] <= bus.write_data;
         model_writes              <= model_writes + 1;
      end
   end

   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr, input bit bypassable);
      if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (bypassable && bus.reg_write && !reset && bus.write_reg == addr) return bus.write_data;
`endif
      return model_regs[addr];
   endfunction

   function automatic logic [31:0] exp_count();
      return 32'(model_writes % 65536);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_rd1", bus.read_data1, exp_read(bus.read_reg1, 1'b1));
         check("model_rd2", bus.read_data2, exp_read(bus.read_reg2, 1'b1));
         check("model_dbg", bus.debug_data, exp_read(bus.debug_reg, 1'b0));
         check("model_cnt", {16'd0, bus.write_count}, exp_count());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.write_reg  = addr;
      bus.write_data = data;
      bus.reg_write  = 1'b1;
      step();
      bus.reg_write  = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      check_en = 1'b0;
      reset    = 1'b1;
      bus.read_reg1  = '0;
      bus.read_reg2  = '0;
      bus.write_reg  = '0;
      bus.write_data = '0;
      bus.reg_write  = 1'b0;
      bus.debug_reg  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      check_en = 1'b1;

      // All addresses on all ports read zero after reset.
      for (int a = 0; a < 32; a++) begin
         bus.read_reg1 = AW'(a);
         bus.read_reg2 = AW'(31 - a);
         bus.debug_reg = AW'(a);
         #1;
         check("rst_rd1", bus.read_data1, 32'h0);
         check("rst_rd2", bus.read_data2, 32'h0);
         check("rst_dbg", bus.debug_data, 32'h0);
      end
      check("rst_cnt", {16'd0, bus.write_count}, 32'd0);

      // Basic write, both ports reading the same register.
      do_write(5, 32'hDEADBEEF);
      bus.read_reg1 = 5;
      bus.read_reg2 = 5;
      #1;
      check("x5_rd1", bus.read_data1, 32'hDEADBEEF);
      check("x5_rd2", bus.read_data2, 32'hDEADBEEF);
      check("x5_cnt", {16'd0, bus.write_count}, 32'd1);

      // Write to x0 is discarded and not counted.
      do_write(0, 32'h12345678);
      bus.read_reg1 = 0;
      #1;
      check("x0_rd1", bus.read_data1, 32'h0);
      check("x0_cnt", {16'd0, bus.write_count}, 32'd1);

      // Same-cycle read of the write target.
      bus.read_reg1  = 7;
      bus.read_reg2  = 7;
      bus.debug_reg  = 7;
      bus.write_reg  = 7;
      bus.write_data = 32'hA5A5A5A5;
      bus.reg_write  = 1'b1;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("x7_pre_rd1", bus.read_data1, 32'hA5A5A5A5);
      check("x7_pre_rd2", bus.read_data2, 32'hA5A5A5A5);
`else
      check("x7_pre_rd1", bus.read_data1, 32'h0);
      check("x7_pre_rd2", bus.read_data2, 32'h0);
`endif
      check("x7_pre_dbg", bus.debug_data, 32'h0);
      step();
      bus.reg_write = 1'b0;
      #1;
      check("x7_post_rd1", bus.read_data1, 32'hA5A5A5A5);
      check("x7_post_dbg", bus.debug_data, 32'hA5A5A5A5);
      check("x7_post_cnt", {16'd0, bus.write_count}, 32'd2);

      // Writes held during reset never commit.
      reset          = 1'b1;
      bus.write_reg  = 3;
      bus.write_data = 32'h55555555;
      bus.reg_write  = 1'b1;
      step();
      step();
      bus.reg_write  = 1'b0;
      reset          = 1'b0;
      bus.debug_reg  = 3;
      bus.read_reg1  = 7;
      #1;
      check("rstwr_dbg", bus.debug_data, 32'h0);
      check("rstwr_rd1", bus.read_data1, 32'h0);
      check("rstwr_cnt", {16'd0, bus.write_count}, 32'd0);

      // Fill x1..x31 with their index, then spot-check distinct addresses.
      for (int i = 1; i < 32; i++) do_write(AW'(i), 32'(i));
      bus.read_reg1 = 12;
      bus.read_reg2 = 30;
      bus.debug_reg = 17;
      #1;
      check("fill_rd1", bus.read_data1, 32'd12);
      check("fill_rd2", bus.read_data2, 32'd30);
      check("fill_dbg", bus.debug_data, 32'd17);
      check("fill_cnt", {16'd0, bus.write_count}, 32'd31);

      // Asynchronous reset between edges clears everything before the next edge.
      bus.read_reg1 = 31;
      bus.read_reg2 = 1;
      reset = 1'b1;
      #1;
      check("arst_rd1", bus.read_data1, 32'h0);
      check("arst_rd2", bus.read_data2, 32'h0);
      check("arst_dbg", bus.debug_data, 32'h0);
      check("arst_cnt", {16'd0, bus.write_count}, 32'd0);
      step();
      reset = 1'b0;

      // Counter wrap: 65537 writes to x1.
      bus.read_reg1 = 1;
      bus.debug_reg = 1;
      for (int i = 1; i <= 65537; i++) begin
         do_write(1, 32'(i));
         if (i == 65535) check("wrap_ffff", {16'd0, bus.write_count}, 32'h0000FFFF);
         if (i == 65536) check("wrap_zero", {16'd0, bus.write_count}, 32'd0);
      end
      #1;
      check("wrap_cnt", {16'd0, bus.write_count}, 32'd1);
      check("wrap_dbg", bus.debug_data, 32'h00010001);

      step();
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
